// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the sequential ALU unit
package alu_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_FUNCT = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SLL = 4'b0001;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_SRL = 4'b0011;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_XOR = 4'b0110;
  localparam logic [3:0] FUNCT_NOR = 4'b0111;
  localparam logic [3:0] FUNCT_MUL = 4'b1000;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;
  localparam logic [3:0] FUNCT_SRA = 4'b1011;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0011;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_SLL = 4'b1000;
  localparam logic [3:0] CTRL_SRL = 4'b1001;
  localparam logic [3:0] CTRL_SRA = 4'b1010;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_MUL = 4'b1110;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] c);
    return (c == CTRL_SLL) || (c == CTRL_SRL) || (c == CTRL_SRA) || (c == CTRL_MUL);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - aluop/funct to control code; MUL decoded only with ALU_SEQ_MUL_EN
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [3:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal,
  output logic       multicycle
);

  always_comb begin
    ctrl = CTRL_ILL;
    case (aluop)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_AND: ctrl = CTRL_AND;
      ALUOP_OR:  ctrl = CTRL_OR;
      ALUOP_SLT: ctrl = CTRL_SLT;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_XOR: ctrl = CTRL_XOR;
          FUNCT_NOR: ctrl = CTRL_NOR;
          FUNCT_SLT: ctrl = CTRL_SLT;
          FUNCT_SLL: ctrl = CTRL_SLL;
          FUNCT_SRL: ctrl = CTRL_SRL;
          FUNCT_SRA: ctrl = CTRL_SRA;
`ifdef ALU_SEQ_MUL_EN
          FUNCT_MUL: ctrl = CTRL_MUL;
`endif
          default:   ctrl = CTRL_ILL;
        endcase
      end
      default: ctrl = CTRL_ILL;
    endcase
  end

  assign illegal    = (ctrl == CTRL_ILL);
  assign multicycle = is_multicycle(ctrl);

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked ALU with iterative shifts; shift-add MUL under ALU_SEQ_MUL_EN
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       ctrl,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q, work_d, busy_res_d;
  logic [CW-1:0]    cnt_q, cnt_load_d;
  logic             out_valid_q, zero_q, err_q;
  logic [WIDTH-1:0] result_q, alu_d;
  logic [3:0]       ctrl_q;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mplier_q, acc_q, acc_d;
`endif

  logic [3:0]     dec_ctrl;
  logic           dec_ill, dec_multi;
  logic [SHW-1:0] shamt;
  logic           accept, start_busy;

  alu_ctrl_decode u_dec (
    .aluop      (aluop),
    .funct      (funct),
    .ctrl       (dec_ctrl),
    .illegal    (dec_ill),
    .multicycle (dec_multi)
  );

  assign shamt      = b[SHW-1:0];
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  // A zero shift amount leaves the multicycle path and completes like a single-cycle op.
  assign start_busy = dec_multi && (cnt_load_d != '0);

  always_comb begin
    cnt_load_d = {1'b0, shamt};
`ifdef ALU_SEQ_MUL_EN
    if (dec_ctrl == CTRL_MUL) cnt_load_d = CW'(WIDTH);
`endif
  end

  always_comb begin
    alu_d = a;
    case (dec_ctrl)
      CTRL_ADD: alu_d = a + b;
      CTRL_SUB: alu_d = a - b;
      CTRL_AND: alu_d = a & b;
      CTRL_OR:  alu_d = a | b;
      CTRL_XOR: alu_d = a ^ b;
      CTRL_NOR: alu_d = ~(a | b);
      CTRL_SLT: alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_ILL: alu_d = '0;
      default:  alu_d = a;
    endcase
  end

  always_comb begin
    case (op_q)
      CTRL_SLL: work_d = work_q << 1;
      CTRL_SRL: work_d = work_q >> 1;
      CTRL_SRA: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default:  work_d = work_q;
    endcase
    busy_res_d = work_d;
`ifdef ALU_SEQ_MUL_EN
    // work_q holds the shifted multiplicand while mplier_q feeds one bit per cycle.
    acc_d = acc_q + (mplier_q[0] ? work_q : '0);
    if (op_q == CTRL_MUL) begin
      work_d     = work_q << 1;
      busy_res_d = acc_d;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= CTRL_AND;
      work_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ctrl_q      <= 4'b0000;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mplier_q    <= '0;
      acc_q       <= '0;
`endif
    end else if (accept) begin
      op_q   <= dec_ctrl;
      work_q <= a;
      cnt_q  <= cnt_load_d;
`ifdef ALU_SEQ_MUL_EN
      mplier_q <= b;
      acc_q    <= '0;
`endif
      if (start_busy) begin
        state_q     <= ST_BUSY;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= alu_d;
        zero_q      <= (alu_d == '0);
        ctrl_q      <= dec_ctrl;
        err_q       <= dec_ill;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      work_q <= work_d;
      cnt_q  <= cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mplier_q <= mplier_q >> 1;
`endif
      if (cnt_q == CW'(1)) begin
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= busy_res_d;
        zero_q      <= (busy_res_d == '0);
        ctrl_q      <= op_q;
        err_q       <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ctrl      = ctrl_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - randomized self-checking bench for alu_seq_unit
module tb_alu_seq_unit;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] a, b, result;
  logic        zero, err;
  logic [3:0]  ctrl;

  int total = 0;
  int bad   = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ctrl      (ctrl),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: operation named by aluop/funct, evaluated with plain arithmetic.
  function automatic void model(input logic [2:0] op, input logic [3:0] fn,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] c,
                                output logic e, output int lat);
    lat = 1;
    r   = 32'd0;
    case (op)
      3'b000: c = 4'b0010;
      3'b001: c = 4'b0110;
      3'b010: c = 4'b0000;
      3'b011: c = 4'b0001;
      3'b101: c = 4'b0111;
      3'b100: begin
        case (fn)
          4'b0000: c = 4'b0010;
          4'b0010: c = 4'b0110;
          4'b0100: c = 4'b0000;
          4'b0101: c = 4'b0001;
          4'b0110: c = 4'b0011;
          4'b0111: c = 4'b1100;
          4'b1010: c = 4'b0111;
          4'b0001: c = 4'b1000;
          4'b0011: c = 4'b1001;
          4'b1011: c = 4'b1010;
          4'b1000: c = MUL_EN ? 4'b1110 : 4'b1111;
          default: c = 4'b1111;
        endcase
      end
      default: c = 4'b1111;
    endcase
    e = (c == 4'b1111);
    case (c)
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b1100: r = ~(x | y);
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin r = x << y[4:0]; lat = 1 + int'(y[4:0]); end
      4'b1001: begin r = x >> y[4:0]; lat = 1 + int'(y[4:0]); end
      4'b1010: begin r = $signed(x) >>> y[4:0]; lat = 1 + int'(y[4:0]); end
      4'b1110: begin r = x * y; lat = 33; end
      default: r = 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [3:0] fn,
                       input logic [31:0] av, input logic [31:0] bv, output int lat);
    @(negedge clk);
    aluop = op; funct = fn; a = av; b = bv;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    aluop = 3'($urandom); funct = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    total++; if (ctrl !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", ctrl); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [31:0] x, y, r;
    logic [3:0]  c;
    logic        e, z;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    int lat;
    v[0] = '{3'b100, 4'b0000, 32'd5, 32'd7, 32'd12, 4'b0010, 1'b0, 1'b0, 1};
    v[1] = '{3'b001, 4'b0000, 32'd3, 32'd3, 32'd0, 4'b0110, 1'b0, 1'b1, 1};
    v[2] = '{3'b101, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1'b0, 1'b0, 1};
    v[3] = '{3'b100, 4'b1011, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1010, 1'b0, 1'b0, 5};
    v[4] = '{3'b100, 4'b1011, 32'h8000_0000, 32'd0, 32'h8000_0000, 4'b1010, 1'b0, 1'b0, 1};
    if (MUL_EN) v[5] = '{3'b100, 4'b1000, 32'd6, 32'd7, 32'd42, 4'b1110, 1'b0, 1'b0, 33};
    else        v[5] = '{3'b100, 4'b1000, 32'd6, 32'd7, 32'd0, 4'b1111, 1'b1, 1'b1, 1};
    for (int i = 0; i < 6; i++) begin
      issue(v[i].op, v[i].fn, v[i].x, v[i].y, lat);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
      total++; if (result !== v[i].r) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, result, v[i].r); end
      total++; if (ctrl !== v[i].c) begin bad++; $display("FAIL dir%0d_ctrl got=%b want=%b", i, ctrl, v[i].c); end
      total++; if (err !== v[i].e) begin bad++; $display("FAIL dir%0d_err got=%b want=%b", i, err, v[i].e); end
      total++; if (zero !== v[i].z) begin bad++; $display("FAIL dir%0d_zero got=%b want=%b", i, zero, v[i].z); end
    end
    drain();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [31:0] x, y, er;
    logic [3:0]  ec;
    logic        ee;
    int          el, lat;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      fn = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      model(op, fn, x, y, er, ec, ee, el);
      issue(op, fn, x, y, lat);
      total++; if (lat !== el) begin bad++; $display("FAIL rnd%0d_latency op=%b fn=%b got=%0d want=%0d", i, op, fn, lat, el); end
      total++; if (result !== er) begin bad++; $display("FAIL rnd%0d_result op=%b fn=%b got=%h want=%h", i, op, fn, result, er); end
      total++; if (ctrl !== ec) begin bad++; $display("FAIL rnd%0d_ctrl got=%b want=%b", i, ctrl, ec); end
      total++; if (err !== ee) begin bad++; $display("FAIL rnd%0d_err got=%b want=%b", i, err, ee); end
      total++; if (zero !== (er == 32'd0)) begin bad++; $display("FAIL rnd%0d_zero got=%b want=%b", i, zero, (er == 32'd0)); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [31:0] er[8];
    logic [3:0]  ec[8];
    logic        ee;
    int          el;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_out_valid got=%b want=1", i, out_valid); end
        total++; if (result !== er[i-1]) begin bad++; $display("FAIL b2b%0d_result got=%h want=%h", i, result, er[i-1]); end
        total++; if (ctrl !== ec[i-1]) begin bad++; $display("FAIL b2b%0d_ctrl got=%b want=%b", i, ctrl, ec[i-1]); end
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready got=%b want=1", i, in_ready); end
      aluop = ops[$urandom_range(0, 4)]; funct = 4'($urandom); a = $urandom; b = $urandom;
      model(aluop, funct, a, b, er[i], ec[i], ee, el);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (result !== er[7] || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_last got=%h/%b want=%h/1", result, out_valid, er[7]); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y, r1, r2;
    @(negedge clk);
    x = $urandom; y = $urandom;
    r1 = x + y;
    aluop = 3'b000; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || result !== r1) begin bad++; $display("FAIL bp_first got=%h/%b want=%h/1", result, out_valid, r1); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (result !== r1) begin bad++; $display("FAIL bp_hold%0d_result got=%h want=%h", k, result, r1); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d_out_valid got=%b want=1", k, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_in_ready got=%b want=0", k, in_ready); end
    end
    x = $urandom; y = $urandom;
    r2 = x | y;
    aluop = 3'b011; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || result !== r2) begin bad++; $display("FAIL bp_no_bubble got=%h/%b want=%h/1", result, out_valid, r2); end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    @(negedge clk);
    if (MUL_EN) begin aluop = 3'b100; funct = 4'b1000; a = 32'd6; b = 32'd7; end
    else        begin aluop = 3'b100; funct = 4'b0001; a = 32'd6; b = 32'd31; end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL busy_state in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstbusy_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rstbusy_result got=%h want=0", result); end
    total++; if (ctrl !== 4'b0000 || err !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL rstbusy_flags got=%b/%b/%b want=0000/0/0", ctrl, err, zero); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstbusy_in_ready got=%b want=1", in_ready); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstbusy_no_result got=%0d valid cycles want=0", seen); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluop = '0; funct = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
